snn_neuron: RTL and testbench
=============================

Name: snn_neuron

Overview:
Single leaky integrate-and-fire (LIF) neuron for the neuromorphic NoC endpoint. Each clock it samples one incoming spike, given as a 12-bit source address, and looks the address up in a fixed 4-entry synapse table. It integrates the matching weight into a saturating membrane potential with linear leak. When the threshold is crossed it emits a one-cycle spike, then enters a refractory period.

Parameters:
ADDR_W, 12, source address width; address 0 is reserved for "no spike"
V_W, 16, membrane potential width (unsigned)
W_W, 16, synaptic weight width (signed two's complement)
THRESHOLD, 100, firing threshold (unsigned, V_W bits)
LEAK, 1, amount subtracted from the potential every non-refractory cycle
V_RESET, 0, potential value after a spike and during refractory
REFRAC, 4, number of refractory cycles after a spike
SYN0_ADDR / SYN0_W, 7 / 120, synapse 0 source address / weight
SYN1_ADDR / SYN1_W, 8 / 40, synapse 1
SYN2_ADDR / SYN2_W, 9 / 60, synapse 2
SYN3_ADDR / SYN3_W, 10 / -30, synapse 3

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  synchronous reset, active-low
source_address  input  ADDR_W  source of the incoming spike this cycle; 0 = idle
spike  output  1  registered output spike, high for exactly one cycle per firing

Behaviour:
- Reset: rst_n low at a rising edge clears v=0, refrac_cnt=0 and spike=0. Reset overrides all other activity, including mid-refractory and same-cycle input.
- Lookup:
  - Compare source_address against SYN0..SYN3 addresses combinationally.
  - With duplicate entries, the lowest index wins.
  - Address 0 or no match gives w=0, so only the leak applies.
- Integration (refrac_cnt==0):
  - sum = v + sign_extend(w) - LEAK, computed at V_W+2 bits signed.
  - v_next = clamp(sum, 0, 2^V_W-1). No underflow and no wrap.
- Fire: if v_next >= THRESHOLD, then on the same edge spike<=1, v<=V_RESET and refrac_cnt<=REFRAC. Otherwise spike<=0 and v<=v_next.
- Refractory (refrac_cnt>0):
  - Each edge: refrac_cnt decrements, v<=V_RESET, spike<=0.
  - source_address is ignored, and leak is not applied.
  - The first input that can integrate is the one sampled at the edge where refrac_cnt is already 0.
- Latency: an address sampled at edge k produces spike high from edge k through edge k+1, i.e. one cycle after presentation. No handshake; input is valid for one cycle only.
- Consecutive spikes are separated by at least REFRAC+1 cycles. REFRAC=0 allows firing on back-to-back cycles.
- Potential is held inside the block. No output other than spike is required.

Test Plan:
- Reset, then source_address=7 for one cycle with v=0 -> v_next=119>=100, so spike=1 for exactly one cycle after the sampling edge, and v=0.
- Address 8 on three consecutive cycles from v=0 -> v=39, then 78, then 117 triggers spike on the third; no spike after the first two.
- Address 9 once (v=59), then 20 idle cycles -> v decrements by 1 per cycle to 39 with no spike; then 60 idle cycles -> v saturates at 0, no wrap.
- Address 10 at v=0 -> v stays 0 (clamped). Unmatched address 0x3FF -> leak only.
- Address 7 fires, then address 7 on each of the next 4 cycles -> ignored, no spike; address 7 on the 5th cycle after firing -> spike again.
- Address 8 twice (v=78), rst_n=0 for one edge during a third address-8 cycle -> no spike, v=0. Subsequent address 8 -> v=39.

Source files
------------

// File: rtl/snn_neuron.sv
// Leaky integrate-and-fire neuron with a fixed 4-entry synapse table.
// It has a saturating unsigned membrane potential, a linear leak and a refractory counter.
module snn_neuron #(
    parameter int unsigned              ADDR_W    = 12,
    parameter int unsigned              V_W       = 16,
    parameter int unsigned              W_W       = 16,
    parameter logic [V_W-1:0]           THRESHOLD = 100,
    parameter logic [V_W-1:0]           LEAK      = 1,
    parameter logic [V_W-1:0]           V_RESET   = 0,
    parameter int unsigned              REFRAC    = 4,
    parameter logic [ADDR_W-1:0]        SYN0_ADDR = 7,
    parameter logic signed [W_W-1:0]    SYN0_W    = 120,
    parameter logic [ADDR_W-1:0]        SYN1_ADDR = 8,
    parameter logic signed [W_W-1:0]    SYN1_W    = 40,
    parameter logic [ADDR_W-1:0]        SYN2_ADDR = 9,
    parameter logic signed [W_W-1:0]    SYN2_W    = 60,
    parameter logic [ADDR_W-1:0]        SYN3_ADDR = 10,
    parameter logic signed [W_W-1:0]    SYN3_W    = -30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] source_address,
    output logic              spike
);

    localparam int unsigned CNT_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int unsigned S_W   = V_W + 2;

    logic [V_W-1:0]          v;
    logic [CNT_W-1:0]        refrac_cnt;
    logic signed [W_W-1:0]   w;
    logic signed [S_W-1:0]   w_ext;
    logic signed [S_W-1:0]   sum;
    logic [V_W-1:0]          v_next;
    logic                    fire;
    logic                    refractory;

    assign refractory = (refrac_cnt != '0);

    // Address 0 always means "no spike", even if a synapse entry is configured as 0.
    // The if/else chain gives the lowest index priority when entries are duplicated.
    always_comb begin
        w = '0;
        if (source_address != '0) begin
            if (source_address == SYN0_ADDR)
                w = SYN0_W;
            else if (source_address == SYN1_ADDR)
                w = SYN1_W;
            else if (source_address == SYN2_ADDR)
                w = SYN2_W;
            else if (source_address == SYN3_ADDR)
                w = SYN3_W;
        end
    end

    // The sum is two bits wider than v, so both the negative case and the
    // overflow above 2^V_W-1 can be seen before clamping.
    always_comb begin
        w_ext = S_W'(w);
        sum   = $signed({2'b00, v}) + w_ext - $signed({2'b00, LEAK});
        if (sum < 0)
            v_next = '0;
        else if (sum > $signed({2'b00, {V_W{1'b1}}}))
            v_next = '1;
        else
            v_next = sum[V_W-1:0];
        fire = (v_next >= THRESHOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v          <= '0;
            refrac_cnt <= '0;
            spike      <= 1'b0;
        end else if (refractory) begin
            v          <= V_RESET;
            refrac_cnt <= refrac_cnt - 1'b1;
            spike      <= 1'b0;
        end else if (fire) begin
            v          <= V_RESET;
            refrac_cnt <= CNT_W'(REFRAC);
            spike      <= 1'b1;
        end else begin
            v          <= v_next;
            spike      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_snn_neuron.sv
// Directed self-checking bench for snn_neuron.
// Expected spike and potential values are computed by hand from the default parameters.
module tb_snn_neuron;

    logic        clk;
    logic        rst_n;
    logic [11:0] source_address;
    logic        spike;

    int unsigned n_checks;
    int unsigned n_fail;

    snn_neuron dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .source_address (source_address),
        .spike          (spike)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one address for one edge, then settle #1 past the edge.
    task automatic step(input logic [11:0] addr);
        source_address = addr;
        @(posedge clk);
        #1;
        source_address = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(12'd0);
        rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic exp_spike, input logic [15:0] exp_v);
        n_checks++;
        if (spike !== exp_spike) begin
            n_fail++;
            $display("FAIL %s spike: got %b expected %b", name, spike, exp_spike);
        end
        n_checks++;
        if (dut.v !== exp_v) begin
            n_fail++;
            $display("FAIL %s v: got %0d expected %0d", name, dut.v, exp_v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        source_address = '0;
        do_reset();
        chk("reset", 1'b0, 16'd0);
    endtask

    task automatic test_single_fire();
        do_reset();
        step(12'd7);
        chk("fire7", 1'b1, 16'd0);
        step(12'd0);
        chk("fire7_onecycle", 1'b0, 16'd0);
    endtask

    task automatic test_accumulate();
        do_reset();
        step(12'd8);
        chk("acc1", 1'b0, 16'd39);
        step(12'd8);
        chk("acc2", 1'b0, 16'd78);
        step(12'd8);
        chk("acc3_fire", 1'b1, 16'd0);
    endtask

    task automatic test_leak();
        logic seen;
        do_reset();
        step(12'd9);
        chk("leak_start", 1'b0, 16'd59);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(12'd0);
            if (spike) seen = 1'b1;
        end
        chk("leak20", seen, 16'd39);
        for (int i = 0; i < 60; i++) begin
            step(12'd0);
            if (spike) seen = 1'b1;
        end
        chk("leak_floor", seen, 16'd0);
    endtask

    task automatic test_clamp_and_nomatch();
        do_reset();
        step(12'd10);
        chk("neg_clamp", 1'b0, 16'd0);
        step(12'd9);
        chk("pre_nomatch", 1'b0, 16'd59);
        step(12'h3FF);
        chk("nomatch_leak", 1'b0, 16'd58);
        step(12'd10);
        chk("neg_weight", 1'b0, 16'd27);
    endtask

    task automatic test_refractory();
        do_reset();
        step(12'd7);
        chk("refr_fire", 1'b1, 16'd0);
        for (int i = 0; i < 4; i++) begin
            step(12'd7);
            chk($sformatf("refr_ignore%0d", i), 1'b0, 16'd0);
        end
        step(12'd7);
        chk("refr_refire", 1'b1, 16'd0);
    endtask

    task automatic test_reset_override();
        do_reset();
        step(12'd8);
        step(12'd8);
        chk("rst_pre", 1'b0, 16'd78);
        rst_n = 1'b0;
        step(12'd8);
        rst_n = 1'b1;
        chk("rst_override", 1'b0, 16'd0);
        step(12'd8);
        chk("rst_after", 1'b0, 16'd39);
        // Reset during refractory must clear the counter so the next input integrates.
        do_reset();
        step(12'd7);
        step(12'd0);
        rst_n = 1'b0;
        step(12'd0);
        rst_n = 1'b1;
        step(12'd8);
        chk("rst_mid_refrac", 1'b0, 16'd39);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_fire();
        test_accumulate();
        test_leak();
        test_clamp_and_nomatch();
        test_refractory();
        test_reset_override();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
